// File: rtl/div2_if.sv
// div2_if: operand/result bundle for the div2 sequential divider.
interface div2_if #(parameter int SIZE = 8);
    logic            start;
    logic [SIZE-1:0] dividend;
    logic [SIZE-1:0] divisor;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] quotient;
    logic [SIZE-1:0] remainder;
    logic            div_by_zero;
    modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
    modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div2.sv
// div2: restoring shift-subtract divider, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's complement operands (truncation toward zero).
module div2 #(parameter int SIZE = 8) (
    input logic   clk,
    input logic   reset,
    div2_if.slave bus
);
    localparam int CW = $clog2(SIZE + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t          state, state_d;
    logic [SIZE-1:0] q, q_d, r, r_d, d, d_d, quo, quo_d, rem, rem_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            dz, dz_d, dbz, dbz_d, done, done_d;
    logic [SIZE:0]   r_sh, t;
    logic [SIZE-1:0] r_it, q_it, a_mag, b_mag, q_res, r_res, dvd_res;
    assign r_sh = {r, q[SIZE-1]};
    assign t    = r_sh - {1'b0, d};
    assign r_it = t[SIZE] ? r_sh[SIZE-1:0] : t[SIZE-1:0];
    assign q_it = {q[SIZE-2:0], ~t[SIZE]};
`ifdef SIGNED_DIV_EN
    // q holds the dividend magnitude while idle-to-zero-divide, so dvd_res restores the original
    logic neg_q, neg_q_d, neg_r, neg_r_d;
    assign a_mag   = bus.dividend[SIZE-1] ? -bus.dividend : bus.dividend;
    assign b_mag   = bus.divisor[SIZE-1] ? -bus.divisor : bus.divisor;
    assign neg_q_d = (state == IDLE && bus.start) ? bus.dividend[SIZE-1] ^ bus.divisor[SIZE-1] : neg_q;
    assign neg_r_d = (state == IDLE && bus.start) ? bus.dividend[SIZE-1] : neg_r;
    assign q_res   = neg_q ? -q_it : q_it;
    assign r_res   = neg_r ? -r_it : r_it;
    assign dvd_res = neg_r ? -q : q;
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            neg_q <= neg_q_d;
            neg_r <= neg_r_d;
        end
    end
`else
    assign a_mag   = bus.dividend;
    assign b_mag   = bus.divisor;
    assign q_res   = q_it;
    assign r_res   = r_it;
    assign dvd_res = q;
`endif
    always_comb begin
        state_d = state;
        q_d     = q;
        r_d     = r;
        d_d     = d;
        cnt_d   = cnt;
        dz_d    = dz;
        quo_d   = quo;
        rem_d   = rem;
        dbz_d   = dbz;
        done_d  = 1'b0;
        if (state == IDLE) begin
            if (bus.start) begin
                state_d = RUN;
                q_d     = a_mag;
                d_d     = b_mag;
                r_d     = '0;
                cnt_d   = CW'(SIZE);
                dz_d    = bus.divisor == '0;
            end
        end else if (dz) begin
            state_d = IDLE;
            done_d  = 1'b1;
            quo_d   = '1;
            rem_d   = dvd_res;
            dbz_d   = 1'b1;
        end else begin
            q_d   = q_it;
            r_d   = r_it;
            cnt_d = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                quo_d   = q_res;
                rem_d   = r_res;
                dbz_d   = 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            q     <= '0;
            r     <= '0;
            d     <= '0;
            cnt   <= '0;
            dz    <= 1'b0;
            quo   <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            q     <= q_d;
            r     <= r_d;
            d     <= d_d;
            cnt   <= cnt_d;
            dz    <= dz_d;
            quo   <= quo_d;
            rem   <= rem_d;
            dbz   <= dbz_d;
            done  <= done_d;
        end
    end
    assign bus.busy        = state == RUN;
    assign bus.done        = done;
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
endmodule
